// File: rtl/fifo_burst_reader.sv
`default_nettype none
// fifo_burst_reader: drains burst_len words from the async FIFO read port onto a
// valid/ready stream through a 2-entry skid buffer. Optional feature macro: RD_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int Data_width     = 8,
  parameter int Addr_width     = 5,
  parameter int Timeout_cycles = 255
) (
  input  logic                  clk_read,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Addr_width:0]   burst_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [Data_width-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Data_width-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [Addr_width:0]   len_q, len_d;
  logic [Addr_width:0]   issued_q, issued_d;
  logic                  inflight_q;
  logic                  zero_done_q, zero_done_d;
  logic [Data_width-1:0] skid_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic [2:0]            occ;
  logic                  pop;
  logic                  flush_done;
  logic                  tmo_hit;

  // Credit: buffered words plus the word on the FIFO data bus may never exceed two.
  always_comb begin
    occ        = {1'b0, count_q} + {2'b00, inflight_q};
    m_valid    = (count_q != 2'd0);
    m_data     = skid_q[rd_ptr_q];
    pop        = m_valid & m_ready;
    fifo_rd_en = (state_q == S_RUN) && !fifo_empty && (issued_q < len_q) &&
                 ((occ <= 3'd1) || ((occ == 3'd2) && pop));
    flush_done = (state_q == S_FLUSH) && (count_q == 2'd0) && !inflight_q;
    busy       = (state_q != S_IDLE);
    done       = flush_done | zero_done_q;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    zero_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d  = S_RUN;
            len_d    = burst_len;
            issued_d = '0;
          end
        end
      end
      S_RUN: begin
        issued_d = issued_q + {{Addr_width{1'b0}}, fifo_rd_en};
        if ((issued_q == len_q) || tmo_hit) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_read or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= fifo_rd_en;
      zero_done_q <= zero_done_d;
    end
  end

  // Capture and pop in one cycle both apply; the occupancy count then stays put.
  always_ff @(posedge clk_read or negedge rst) begin
    if (!rst) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (inflight_q) begin
        skid_q[wr_ptr_q] <= fifo_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(Timeout_cycles + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  // Abort fires on the cycle that completes the run of empty cycles, so FLUSH follows directly.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    tmo_hit    = 1'b0;
    if ((state_q == S_IDLE) && start) begin
      tmo_cnt_d  = '0;
      tmo_flag_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (fifo_empty && (issued_q < len_q)) begin
        if (tmo_cnt_q == TMO_W'(Timeout_cycles - 1)) begin
          tmo_hit    = 1'b1;
          tmo_flag_d = 1'b1;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end else begin
        tmo_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_read or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign timeout = flush_done & tmo_flag_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire
